// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-master AXI read-address arbiter.
// Grants one master at a time onto the slave AR port, stamps ARID per
// master, and tracks outstanding bursts per master from R-channel last
// beats. A master stops being granted while its count is at the limit.
// Optional build macro AXI_RD_ARB_FIXED_PRIO_EN: m0 always wins a tie
// (default build: round-robin on ties).
module axi_read_arbiter #(
  parameter int         ADDR_WIDTH      = 32,
  parameter int         MAX_OUTSTANDING = 4,
  parameter logic [7:0] M0_ID           = 8'h01,
  parameter logic [7:0] M1_ID           = 8'h02
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_ARVALID,
  output logic                  m0_ARREADY,
  input  logic [ADDR_WIDTH-1:0] m0_ARADDR,
  input  logic [7:0]            m0_ARLEN,
  input  logic [2:0]            m0_ARSIZE,
  input  logic [1:0]            m0_ARBURST,
  input  logic                  m1_ARVALID,
  output logic                  m1_ARREADY,
  input  logic [ADDR_WIDTH-1:0] m1_ARADDR,
  input  logic [7:0]            m1_ARLEN,
  input  logic [2:0]            m1_ARSIZE,
  input  logic [1:0]            m1_ARBURST,
  output logic                  s_ARVALID,
  input  logic                  s_ARREADY,
  output logic [7:0]            s_ARID,
  output logic [ADDR_WIDTH-1:0] s_ARADDR,
  output logic [7:0]            s_ARLEN,
  output logic [2:0]            s_ARSIZE,
  output logic [1:0]            s_ARBURST,
  input  logic [7:0]            rid,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic                  rlast,
  output logic                  m0_busy,
  output logic                  m1_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  state_t     state_reg;
  logic       last_grant_reg;  // 0: m0 was granted last, 1: m1
  logic [3:0] cnt0_reg;
  logic [3:0] cnt1_reg;
  logic [3:0] cnt0_next;
  logic [3:0] cnt1_next;

  logic elig0, elig1;
  logic hs0, hs1;
  logic ret0, ret1;
  logic pick1;

  assign elig0 = m0_ARVALID && (cnt0_reg < MAX_CNT);
  assign elig1 = m1_ARVALID && (cnt1_reg < MAX_CNT);

  // AR handshake completes only while the owning master is granted
  assign hs0 = (state_reg == GNT0) && m0_ARVALID && s_ARREADY;
  assign hs1 = (state_reg == GNT1) && m1_ARVALID && s_ARREADY;

  // Last R beat retires one burst; a return against an empty counter is dropped
  assign ret0 = rvalid && rready && rlast && (rid == M0_ID) && (cnt0_reg != 4'd0);
  assign ret1 = rvalid && rready && rlast && (rid == M1_ID) && (cnt1_reg != 4'd0);

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  assign pick1 = elig1 && !elig0;
`else
  // On a tie, favour whichever master did not win last time
  assign pick1 = elig1 && (!elig0 || !last_grant_reg);
`endif

  // Outstanding counters: an issue and a retire in the same cycle cancel out
  always_comb begin
    cnt0_next = cnt0_reg;
    cnt1_next = cnt1_reg;
    if (hs0 && !ret0)
      cnt0_next = cnt0_reg + 4'd1;
    else if (!hs0 && ret0)
      cnt0_next = cnt0_reg - 4'd1;
    if (hs1 && !ret1)
      cnt1_next = cnt1_reg + 4'd1;
    else if (!hs1 && ret1)
      cnt1_next = cnt1_reg - 4'd1;
  end

  // Grant FSM, round-robin history and counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cnt0_reg       <= 4'd0;
      cnt1_reg       <= 4'd0;
    end else begin
      cnt0_reg <= cnt0_next;
      cnt1_reg <= cnt1_next;
      case (state_reg)
        IDLE: begin
          if (elig0 || elig1)
            state_reg <= pick1 ? GNT1 : GNT0;
        end
        GNT0: begin
          if (hs0) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b0;
          end else if (!m0_ARVALID) begin
            state_reg <= IDLE;
          end
        end
        GNT1: begin
          if (hs1) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
          end else if (!m1_ARVALID) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Slave AR port and master ready follow the granted master combinationally
  always_comb begin
    s_ARVALID  = 1'b0;
    s_ARID     = 8'h00;
    s_ARADDR   = '0;
    s_ARLEN    = 8'h00;
    s_ARSIZE   = 3'd0;
    s_ARBURST  = 2'd0;
    m0_ARREADY = 1'b0;
    m1_ARREADY = 1'b0;
    case (state_reg)
      GNT0: begin
        s_ARVALID  = m0_ARVALID;
        s_ARID     = M0_ID;
        s_ARADDR   = m0_ARADDR;
        s_ARLEN    = m0_ARLEN;
        s_ARSIZE   = m0_ARSIZE;
        s_ARBURST  = m0_ARBURST;
        m0_ARREADY = s_ARREADY;
      end
      GNT1: begin
        s_ARVALID  = m1_ARVALID;
        s_ARID     = M1_ID;
        s_ARADDR   = m1_ARADDR;
        s_ARLEN    = m1_ARLEN;
        s_ARSIZE   = m1_ARSIZE;
        s_ARBURST  = m1_ARBURST;
        m1_ARREADY = s_ARREADY;
      end
      default: ;
    endcase
  end

  assign m0_busy = (cnt0_reg == MAX_CNT);
  assign m1_busy = (cnt1_reg == MAX_CNT);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: vector table, hand sequences for reset and
// alternation, then randomized traffic against a per-master model.
module tb_axi_read_arbiter;

  localparam int AW   = 32;
  localparam int MAXO = 4;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_ARVALID, m1_ARVALID, m0_ARREADY, m1_ARREADY;
  logic [AW-1:0] m0_ARADDR, m1_ARADDR, s_ARADDR;
  logic [7:0]    m0_ARLEN, m1_ARLEN, s_ARLEN;
  logic [2:0]    m0_ARSIZE, m1_ARSIZE, s_ARSIZE;
  logic [1:0]    m0_ARBURST, m1_ARBURST, s_ARBURST;
  logic          s_ARVALID, s_ARREADY;
  logic [7:0]    s_ARID, rid;
  logic          rvalid, rready, rlast;
  logic          m0_busy, m1_busy;

  axi_read_arbiter #(
    .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO), .M0_ID(8'h01), .M1_ID(8'h02)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY), .m0_ARADDR(m0_ARADDR),
    .m0_ARLEN(m0_ARLEN), .m0_ARSIZE(m0_ARSIZE), .m0_ARBURST(m0_ARBURST),
    .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY), .m1_ARADDR(m1_ARADDR),
    .m1_ARLEN(m1_ARLEN), .m1_ARSIZE(m1_ARSIZE), .m1_ARBURST(m1_ARBURST),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARID(s_ARID),
    .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
    .s_ARBURST(s_ARBURST), .rid(rid), .rvalid(rvalid), .rready(rready),
    .rlast(rlast), .m0_busy(m0_busy), .m1_busy(m1_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int m0v, m1v, sr, rb, rid;
    int sv, id, r0, r1, b0, b1;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic v(input int a, b, sr, rb, r, sv, id, r0, r1, b0, b1);
    vec_t e;
    e.m0v = a; e.m1v = b; e.sr = sr; e.rb = rb; e.rid = r;
    e.sv = sv; e.id = id; e.r0 = r0; e.r1 = r1; e.b0 = b0; e.b1 = b1;
    vq.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge, settle, return for checks
  task automatic step(input int a, b, sr, rb, r);
    @(negedge clk);
    m0_ARVALID = a[0];
    m1_ARVALID = b[0];
    s_ARREADY  = sr[0];
    rvalid     = rb[0];
    rready     = rb[0];
    rlast      = rb[0];
    rid        = r[7:0];
    #1;
  endtask

  // Fixed field set: m0 = 0x1000/len 3, m1 = 0x2000/len 1
  task automatic chk_outs(input string tag, input int sv, id, r0, r1, b0, b1);
    int ea, el;
    ea = (id == 1) ? 32'h1000 : (id == 2) ? 32'h2000 : 0;
    el = (id == 1) ? 3 : (id == 2) ? 1 : 0;
    chk({tag, " s_ARVALID"}, int'(s_ARVALID), sv);
    chk({tag, " s_ARID"}, int'(s_ARID), id);
    chk({tag, " s_ARADDR"}, int'(s_ARADDR), ea);
    chk({tag, " s_ARLEN"}, int'(s_ARLEN), el);
    chk({tag, " m0_ARREADY"}, int'(m0_ARREADY), r0);
    chk({tag, " m1_ARREADY"}, int'(m1_ARREADY), r1);
    chk({tag, " m0_busy"}, int'(m0_busy), b0);
    chk({tag, " m1_busy"}, int'(m1_busy), b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int owner, last, grants;
    int cnt[2];
    int inc[2];
    int dec[2];
    int mv[2];
    int e_sv, e_id, e_addr, e_len, e_size, e_burst, e_r0, e_r1;
    int addr[2], len[2], size[2], burst[2];
    int e0, e1, ri, owner_n;
    string t;

    m0_ARVALID = 0; m1_ARVALID = 0; s_ARREADY = 0;
    rvalid = 0; rready = 0; rlast = 0; rid = 8'h00;
    m0_ARADDR = 32'h1000; m0_ARLEN = 8'd3; m0_ARSIZE = 3'd2; m0_ARBURST = 2'd1;
    m1_ARADDR = 32'h2000; m1_ARLEN = 8'd1; m1_ARSIZE = 3'd3; m1_ARBURST = 2'd2;

    // Reset values while rst is held
    repeat (3) @(negedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    chk("reset s_ARSIZE", int'(s_ARSIZE), 0);
    chk("reset s_ARBURST", int'(s_ARBURST), 0);
    rst = 0;

    // Vector table from reset: issue, limit, retire, stall, inc+dec, stray rid, underflow
    v(1,0,1,0,0, 0,0,0,0,0,0);
    v(1,0,1,0,0, 1,1,1,0,0,0);
    for (int k = 0; k < 3; k++) begin
      v(1,0,1,0,0, 0,0,0,0,0,0);
      v(1,0,1,0,0, 1,1,1,0,0,0);
    end
    v(1,0,1,0,0, 0,0,0,0,1,0);
    v(1,1,1,0,0, 0,0,0,0,1,0);
    v(1,1,1,0,0, 1,2,0,1,1,0);
    v(1,0,1,1,1, 0,0,0,0,1,0);
    v(1,0,1,0,0, 0,0,0,0,0,0);
    v(1,0,1,0,0, 1,1,1,0,0,0);
    v(0,0,1,1,1, 0,0,0,0,1,0);
    v(0,1,1,0,0, 0,0,0,0,0,0);
    for (int k = 0; k < 5; k++) v(1,1,0,0,0, 1,2,0,0,0,0);
    v(1,1,1,0,0, 1,2,0,1,0,0);
    v(1,1,1,0,0, 0,0,0,0,0,0);
    v(1,1,1,0,0, 1,1,1,0,0,0);
    v(1,1,1,0,0, 0,0,0,0,1,0);
    v(0,1,1,1,2, 1,2,0,1,1,0);
    v(0,0,1,1,7, 0,0,0,0,1,0);
    for (int k = 0; k < 2; k++) begin
      v(0,1,1,0,0, 0,0,0,0,1,0);
      v(0,1,1,0,0, 1,2,0,1,1,0);
    end
    v(0,0,1,1,2, 0,0,0,0,1,1);
    for (int k = 0; k < 4; k++) v(0,0,1,1,2, 0,0,0,0,1,0);
    for (int k = 0; k < 4; k++) begin
      v(0,1,1,0,0, 0,0,0,0,1,0);
      v(0,1,1,0,0, 1,2,0,1,1,0);
    end
    v(0,1,1,0,0, 0,0,0,0,1,1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].m0v, vq[i].m1v, vq[i].sr, vq[i].rb, vq[i].rid);
      chk_outs($sformatf("vec%0d", i), vq[i].sv, vq[i].id, vq[i].r0,
               vq[i].r1, vq[i].b0, vq[i].b1);
      if (vq[i].sv != 0 && vq[i].sr != 0)
        $display("vec%0d: AR handshake id=%02h addr=%08h", i, s_ARID, s_ARADDR);
    end

    // Asynchronous reset while m0 is granted and presenting a request
    step(0,0,1,1,1); chk_outs("rstA0", 0,0,0,0,1,1);
    step(1,0,0,0,0); chk_outs("rstA1", 0,0,0,0,0,1);
    step(1,0,0,0,0); chk_outs("rstA2", 1,1,0,0,0,1);
    #2;
    s_ARREADY = 1;
    rst = 1;
    #1;
    chk("rstA async s_ARVALID", int'(s_ARVALID), 0);
    chk("rstA async m0_ARREADY", int'(m0_ARREADY), 0);
    chk("rstA async s_ARID", int'(s_ARID), 0);
    m0_ARVALID = 0;
    @(negedge clk);
    #1;
    chk("rstA cleared m0_busy", int'(m0_busy), 0);
    chk("rstA cleared m1_busy", int'(m1_busy), 0);
    rst = 0;

    // Both masters requesting continuously after reset
    for (int k = 0; k < 8; k++) begin
      step(1,1,1,0,0);
      if (k % 2 == 0)
        chk_outs($sformatf("alt%0d", k), 0,0,0,0,0,0);
      else if (FIXED || k == 1 || k == 5)
        chk_outs($sformatf("alt%0d", k), 1,1,1,0,0,0);
      else
        chk_outs($sformatf("alt%0d", k), 1,2,0,1,0,0);
    end
    step(0,0,1,0,0);
    chk("alt end m0_busy", int'(m0_busy), FIXED ? 1 : 0);

    // Randomized traffic against the model
    @(negedge clk);
    rst = 1;
    m0_ARVALID = 0; m1_ARVALID = 0; rvalid = 0;
    @(negedge clk);
    rst = 0;
    owner = -1; last = 1; cnt[0] = 0; cnt[1] = 0; grants = 0;

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      mv[0] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      mv[1] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      for (int m = 0; m < 2; m++) begin
        addr[m]  = int'($urandom);
        len[m]   = int'($urandom_range(0, 255));
        size[m]  = int'($urandom_range(0, 7));
        burst[m] = int'($urandom_range(0, 3));
      end
      m0_ARVALID = mv[0][0]; m1_ARVALID = mv[1][0];
      m0_ARADDR = addr[0]; m0_ARLEN = len[0][7:0];
      m0_ARSIZE = size[0][2:0]; m0_ARBURST = burst[0][1:0];
      m1_ARADDR = addr[1]; m1_ARLEN = len[1][7:0];
      m1_ARSIZE = size[1][2:0]; m1_ARBURST = burst[1][1:0];
      s_ARREADY = ($urandom_range(0, 3) != 0);
      rvalid    = ($urandom_range(0, 2) == 0);
      rready    = ($urandom_range(0, 3) != 0);
      rlast     = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: rid = 8'h01;
        1: rid = 8'h02;
        2: rid = 8'h07;
        default: rid = 8'h01;
      endcase
      #1;

      // Expected outputs from the current owner
      e_sv = 0; e_id = 0; e_addr = 0; e_len = 0; e_size = 0; e_burst = 0;
      e_r0 = 0; e_r1 = 0;
      if (owner >= 0) begin
        e_sv = mv[owner];
        e_id = owner + 1;
        e_addr = addr[owner]; e_len = len[owner];
        e_size = size[owner]; e_burst = burst[owner];
        if (owner == 0) e_r0 = int'(s_ARREADY);
        else            e_r1 = int'(s_ARREADY);
      end
      t = $sformatf("rnd%0d", i);
      chk({t, " s_ARVALID"}, int'(s_ARVALID), e_sv);
      chk({t, " s_ARID"}, int'(s_ARID), e_id);
      chk({t, " s_ARADDR"}, int'(s_ARADDR), e_addr);
      chk({t, " s_ARLEN"}, int'(s_ARLEN), e_len);
      chk({t, " s_ARSIZE"}, int'(s_ARSIZE), e_size);
      chk({t, " s_ARBURST"}, int'(s_ARBURST), e_burst);
      chk({t, " m0_ARREADY"}, int'(m0_ARREADY), e_r0);
      chk({t, " m1_ARREADY"}, int'(m1_ARREADY), e_r1);
      chk({t, " m0_busy"}, int'(m0_busy), (cnt[0] == MAXO) ? 1 : 0);
      chk({t, " m1_busy"}, int'(m1_busy), (cnt[1] == MAXO) ? 1 : 0);

      // Advance the model by one clock edge
      inc[0] = 0; inc[1] = 0; dec[0] = 0; dec[1] = 0;
      owner_n = owner;
      if (owner >= 0) begin
        if (mv[owner] == 1 && s_ARREADY) begin
          inc[owner] = 1;
          last = owner;
          owner_n = -1;
          grants++;
          $display("rnd%0d: AR grant %0d id=%02h addr=%08h len=%0d", i, grants,
                   s_ARID, s_ARADDR, s_ARLEN);
        end else if (mv[owner] == 0) begin
          owner_n = -1;
        end
      end else begin
        e0 = (mv[0] == 1 && cnt[0] < MAXO) ? 1 : 0;
        e1 = (mv[1] == 1 && cnt[1] < MAXO) ? 1 : 0;
        if (e0 == 1 && e1 == 1) owner_n = FIXED ? 0 : 1 - last;
        else if (e0 == 1)       owner_n = 0;
        else if (e1 == 1)       owner_n = 1;
      end
      if (rvalid && rready && rlast) begin
        ri = (rid == 8'h01) ? 0 : (rid == 8'h02) ? 1 : -1;
        if (ri >= 0 && cnt[ri] > 0) dec[ri] = 1;
      end
      for (int m = 0; m < 2; m++) cnt[m] = cnt[m] + inc[m] - dec[m];
      owner = owner_n;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
